snake_dir_ctrl: RTL
===================

// Module: snake_dir_ctrl
// PURPOSE
// Parametrised N-player direction controller for the snake game. Replaces the
// combinational button-to-move decode with synchronised, debounced, edge-detected
// input, a per-player turn queue and commit on the game tick. Output dir feeds
// regfile move registers; direction codes are 1=up, 2=right, 3=down, 4=left.
// PARAMETERS
// N_PLAYERS  2      number of independent players/channels
// DB_CYCLES  50000  stable cycles needed to accept a button level (1 ms @ 50 MHz)
// DB_W       16     debounce counter width, must hold DB_CYCLES
// QDEPTH     2      per-player pending-turn queue depth (>=1)
// DIR_W      32     width of each per-player direction word
// INIT_DIR   2      direction loaded on reset (right)
// PORTS
// clock      in   1            system clock, all logic on posedge
// reset      in   1            synchronous, active-high
// btn_n      in   4*N_PLAYERS  per player p bits [4p+3:4p] = {left,down,right,up}, active-low
// tick       in   1            game-step strobe; commits one queued turn per player
// enable     in   1            0 = game halted: presses and ticks ignored, queues flushed
// dir        out  DIR_W*N      committed direction, player p at [DIR_W*(p+1)-1:DIR_W*p]
// turned     out  N_PLAYERS    1-cycle pulse: player's dir changed this cycle
// q_full     out  N_PLAYERS    player's queue holds QDEPTH entries
// BEHAVIOUR
// - Reset: dir=INIT_DIR (zero-extended), turned=0, q_full=0, queues empty,
//   sync/stable button state=1 (released), debounce counters=0.
// - Sync: 2-flop synchroniser per button.
// - Debounce: counter increments while synced != stable, clears when equal;
//   at count DB_CYCLES-1 stable takes synced value and counter clears.
// - Press: 1-cycle pulse on stable 1->0; holding never repeats; release ignored.
// - Latency: btn edge -> press pulse = 2 + DB_CYCLES + 1 cycles.
// - Same-cycle presses in one player: priority up>right>down>left, rest dropped.
// - Validation reference = queue tail if non-empty, else committed dir.
//   Reject candidate equal to reference or its opposite (1<->3, 2<->4).
// - Accepted candidate pushed next edge. Queue full and no pop: drop new press.
// - Tick with enable=1: each player with non-empty queue pops head into dir on
//   the same edge; turned=1 for the following cycle. Empty queue: dir held, turned=0.
// - Push+pop same cycle: pop first, so push succeeds even when full; count unchanged.
//   Reference (tail) unaffected by pop, so validation result identical.
// - tick held high: one pop per cycle. tick=1 with enable=0: ignored.
// - enable=0: queues cleared next edge, dir held, presses discarded, debounce runs.
// - Reset mid-operation: all state returns to reset values next edge; pending
//   presses lost.
// - Players fully independent; no cross-player ordering.
// STRUCTURE
// - Package snake_pkg: DIR_UP/RIGHT/DOWN/LEFT constants (3-bit), function
//   dir_opposite(), DIR_NONE=0.
// - Sub-module btn_debounce (params DB_CYCLES, DB_W): sync + debounce + press pulse
//   for one button; instantiated 4*N_PLAYERS times via generate.
// - Top: generate loop per player: priority encode, validate, circular queue
//   (head/tail pointers, count), dir register.
// TESTING (bench uses DB_CYCLES=4, N_PLAYERS=2, QDEPTH=2)
// - Reset: after reset dir=2,2, turned=0, q_full=0; btn_n all 1 for 100 cycles -> no change.
// - Bounce: p0 up toggles every 2 cycles for 20 cycles then held 0 -> exactly one push;
//   next tick -> dir0=1, turned[0] pulses one cycle, dir1 stays 2.
// - Reversal: dir0=2, press left -> rejected; press right -> rejected; queue stays empty.
// - Queue: dir0=2, press up then left (no tick) -> q_full[0]=1; press down -> dropped;
//   two ticks -> dir0=1 then 4.
// - Push+pop full: queue full, press valid turn on tick cycle -> accepted, q_full stays 1.
// - enable=0 with 2 queued -> queue flushed, tick ignored, dir held; reset during
//   debounce count -> dir=2, no press emitted.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction codes and helpers shared by the snake direction controller
package snake_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_NONE  = 3'd0;
    localparam dir_t DIR_UP    = 3'd1;
    localparam dir_t DIR_RIGHT = 3'd2;
    localparam dir_t DIR_DOWN  = 3'd3;
    localparam dir_t DIR_LEFT  = 3'd4;

    // Reversing into yourself is illegal, so validation needs the opposite heading.
    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_RIGHT: return DIR_LEFT;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Press bits are {left,down,right,up}; same-cycle presses resolve up > right > down > left.
    function automatic dir_t dir_pick(input logic [3:0] p);
        if (p[0]) return DIR_UP;
        else if (p[1]) return DIR_RIGHT;
        else if (p[2]) return DIR_DOWN;
        else if (p[3]) return DIR_LEFT;
        else return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser, debouncer and press-edge pulse for one active-low button
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_a;
    logic            sync_b;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn_n;
            sync_b <= sync_a;
        end
    end

    // A new level is only accepted after it has disagreed with stable for DB_CYCLES cycles in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync_b == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_b;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered pulse on the accepted 1->0 transition only; holding or releasing yields nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - N-player snake direction controller with per-player turn queues
module snake_dir_ctrl #(
    parameter int N_PLAYERS = 2,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16,
    parameter int QDEPTH    = 2,
    parameter int DIR_W     = 32,
    parameter int INIT_DIR  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [4*N_PLAYERS-1:0]       btn_n,
    input  logic                         tick,
    input  logic                         enable,
    output logic [DIR_W*N_PLAYERS-1:0]   dir,
    output logic [N_PLAYERS-1:0]         turned,
    output logic [N_PLAYERS-1:0]         q_full
);

    import snake_pkg::*;

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [4*N_PLAYERS-1:0] press;

    for (genvar b = 0; b < 4*N_PLAYERS; b++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .btn_n (btn_n[b]),
            .press (press[b])
        );
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        dir_t             q_mem [QDEPTH];
        logic [PTR_W-1:0] head;
        logic [PTR_W-1:0] tail;
        logic [PTR_W-1:0] head_nxt;
        logic [PTR_W-1:0] tail_nxt;
        logic [PTR_W-1:0] tail_prev;
        logic [CNT_W-1:0] count;
        logic [DIR_W-1:0] dir_q;
        logic             turned_q;
        dir_t             cand;
        dir_t             ref_dir;
        logic             valid;
        logic             pop;
        logic             push;

        // Validate the winning press against the newest pending turn (or the live heading if none).
        always_comb begin
            head_nxt  = (head == PTR_LAST) ? '0 : head + 1'b1;
            tail_nxt  = (tail == PTR_LAST) ? '0 : tail + 1'b1;
            tail_prev = (tail == '0) ? PTR_LAST : tail - 1'b1;
            cand      = dir_pick(press[4*p +: 4]);
            ref_dir   = (count != '0) ? q_mem[tail_prev] : dir_q[2:0];
            valid     = enable && (cand != DIR_NONE) && (cand != ref_dir)
                        && (cand != dir_opposite(ref_dir));
            pop       = enable && tick && (count != '0);
            // Popping frees a slot on the same edge, so a full queue still takes the push.
            push      = valid && ((count != FULL_CNT) || pop);
        end

        // Queue bookkeeping and commit of the head turn on each enabled tick.
        always_ff @(posedge clock) begin
            if (reset) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                dir_q    <= DIR_W'(INIT_DIR);
                turned_q <= 1'b0;
            end else if (!enable) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                turned_q <= 1'b0;
            end else begin
                turned_q <= pop;
                if (pop) begin
                    dir_q <= DIR_W'(q_mem[head]);
                    head  <= head_nxt;
                end
                if (push) begin
                    tail <= tail_nxt;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Entry storage needs no reset: count gates every read.
        always_ff @(posedge clock) begin
            if (push) begin
                q_mem[tail] <= cand;
            end
        end

        assign dir[DIR_W*p +: DIR_W] = dir_q;
        assign turned[p]             = turned_q;
        assign q_full[p]             = (count == FULL_CNT);
    end

endmodule
